mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the pipeline and the single byte-wide synchronous RAM port. It arbitrates between instruction fetch (IF) and data access (MEM) and serialises 1/2/4-byte transfers into byte cycles. It generates `stallreq_from_mem`, which the stall controller consumes to freeze the first four pipeline stages.

## Interface
No parameters.

- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF requests a 4-byte instruction read
- if_addr  in  32  IF byte address
- if_done  out  1  one-cycle pulse: `if_inst` valid
- if_inst  out  32  fetched instruction, little-endian
- mem_req  in  1  MEM requests a load or store
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  MEM byte address
- mem_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- mem_wdata  in  32  store data; the low `size` bytes are used
- mem_done  out  1  one-cycle pulse: access complete, `mem_rdata` valid for loads
- mem_rdata  out  32  load data, zero-extended, little-endian
- stallreq_from_mem  out  1  combinational: `mem_req & ~mem_done`
- stallreq_from_if  out  1  combinational: `if_req & ~if_done`
- ram_a  out  32  RAM byte address (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_wr  out  1  RAM write enable (registered)
- ram_din  in  8  RAM read byte, for the address presented in the previous cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- Internal registers: byte counter `cnt` (3 bits), length `N`, source flag (IF or MEM), latched address, write data, and a 32-bit assembly buffer.
- **IDLE**
  - If `mem_req` is high, accept the MEM request. MEM has priority when both requests are high.
  - Otherwise, if `if_req` is high, accept the IF request with N = 4.
  - On accept: latch address, size and data; clear the buffer; go to READ (load or IF) or WRITE (store).
- **READ**
  - Cycle k = 1..N of the transfer drives `ram_a = addr + (k-1)` with `ram_wr = 0`.
  - Cycles 2..N+1 capture `ram_din` into buffer byte (k-2).
  - After the last capture, go to DONE.
- **WRITE**
  - Cycle k = 1..N drives `ram_a = addr + (k-1)`, `ram_dout = wdata[8(k-1)+7 : 8(k-1)]` and `ram_wr = 1`.
  - Then go to DONE.
- **DONE**
  - Pulse `if_done` or `mem_done` (by source flag) for exactly one cycle.
  - Drive the buffer onto `if_inst` or `mem_rdata`. Unfilled upper bytes are 0.
  - Ignore requests in this cycle and return to IDLE.
- An in-progress transfer is never pre-empted. A MEM request arriving during an IF transfer waits for that transfer's DONE plus one IDLE cycle.
- Address increment is 32-bit with wrap-around: 0xFFFFFFFF + 1 = 0. No alignment check.
- Requester contract: hold `req` and all fields stable from assertion until its done pulse. Deassert `req` or present a new request from the cycle after done.
- `if_inst` and `mem_rdata` hold their last value until the next done of the same source.

## Timing
- Request seen in IDLE at cycle 0.
  - Load or fetch of N bytes: done at cycle N+2. A word takes 6 cycles; a byte takes 3.
  - Store of N bytes: `ram_wr` is high in cycles 1..N; done at cycle N+1.
- The earliest next accept is the cycle after DONE. Back-to-back word fetches therefore run every 7 cycles.
- `ram_wr` is never high outside WRITE. `ram_a` holds its last value while idle.
- Reset values: state IDLE; `ram_a`, `ram_dout`, `ram_wr`, `if_done`, `mem_done`, `if_inst`, `mem_rdata`, `cnt` all 0.
- Reset mid-transfer aborts at that edge: `ram_wr` is 0 in the next cycle, no done pulse is produced, and the partial buffer is discarded.
- The stall outputs are combinational from the inputs and done. During reset they follow `mem_req` and `if_req` with done = 0; the stall controller masks them.

## Test plan
- **Word fetch:** RAM[0x10..0x13] = 13 05 00 00. `if_req` with `if_addr = 0x10` at cycle 0 -> `ram_a` = 0x10..0x13 in cycles 1-4; `if_done` pulses at cycle 6; `if_inst = 0x00000513`; `stallreq_from_if` high cycles 0-5.
- **Byte load:** `mem_size = 0`, addr 0x21, RAM[0x21] = 0xAB -> `mem_done` at cycle 3; `mem_rdata = 0x000000AB`; `stallreq_from_mem` high cycles 0-2.
- **Halfword store:** addr 0x100, `wdata = 0x1234BEEF`, size 1 -> `ram_wr = 1` with (0x100, 0xEF) and (0x101, 0xBE) in cycles 1-2; `mem_done` at cycle 3; RAM[0x102] unchanged.
- **Arbitration:** `if_req` and `mem_req` both high at cycle 0 -> MEM served first, IF accepted the cycle after `mem_done`. Separately, IF in progress when `mem_req` rises at cycle 2 -> IF completes at cycle 6, MEM accepted at cycle 7.
- **Wrap-around:** word load at 0xFFFFFFFE -> `ram_a` sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- **Reset during store:** `rst` asserted in cycle 2 of a word store -> `ram_wr = 0` in cycle 3, no `mem_done`, all outputs return to reset values, and the next request proceeds normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF/MEM requests onto a single
// byte-wide synchronous RAM port and assembles/scatters 1/2/4-byte transfers.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem,
  output logic        stallreq_from_if,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic        src_mem;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] buf_reg;
  logic [31:0] next_buf;
  logic [1:0]  cap_idx;
  logic [7:0]  next_wbyte;
  logic [2:0]  mem_len;

  assign stallreq_from_mem = mem_req & ~mem_done;
  assign stallreq_from_if  = if_req & ~if_done;

  assign mem_len = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;

  // Transfer cycle k captures the byte addressed in cycle k-1 into lane k-2.
  assign cap_idx = 2'(cnt - 3'd2);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign next_buf[8*gi +: 8] = (cap_idx == 2'(gi)) ? ram_din : buf_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    next_wbyte = wdata_reg[7:0];
    case (cnt[1:0])
      2'd1:    next_wbyte = wdata_reg[15:8];
      2'd2:    next_wbyte = wdata_reg[23:16];
      2'd3:    next_wbyte = wdata_reg[31:24];
      default: next_wbyte = wdata_reg[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      len       <= 3'd0;
      src_mem   <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      buf_reg   <= 32'd0;
      ram_a     <= 32'd0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            src_mem   <= 1'b1;
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
            len       <= mem_len;
            buf_reg   <= 32'd0;
            cnt       <= 3'd1;
            ram_a     <= mem_addr;
            if (mem_we) begin
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              state    <= WRITE;
            end else begin
              ram_wr <= 1'b0;
              state  <= READ;
            end
          end else if (if_req) begin
            src_mem  <= 1'b0;
            addr_reg <= if_addr;
            len      <= 3'd4;
            buf_reg  <= 32'd0;
            cnt      <= 3'd1;
            ram_a    <= if_addr;
            ram_wr   <= 1'b0;
            state    <= READ;
          end
        end
        READ: begin
          if (cnt >= 3'd2) buf_reg <= next_buf;
          if (cnt < len) ram_a <= addr_reg + 32'(cnt);
          if (cnt == len + 3'd1) begin
            state <= DONE;
            if (src_mem) begin
              mem_done  <= 1'b1;
              mem_rdata <= next_buf;
            end else begin
              if_done <= 1'b1;
              if_inst <= next_buf;
            end
          end
          cnt <= cnt + 3'd1;
        end
        WRITE: begin
          if (cnt < len) begin
            ram_a    <= addr_reg + 32'(cnt);
            ram_dout <= next_wbyte;
            cnt      <= cnt + 3'd1;
          end else begin
            ram_wr    <= 1'b0;
            state     <= DONE;
            mem_done  <= 1'b1;
            mem_rdata <= buf_reg;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: table vectors, corner-case sequences and random
// transactions checked against a byte-array reference memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        stallreq_from_mem;
  logic        stallreq_from_if;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stallreq_from_mem(stallreq_from_mem), .stallreq_from_if(stallreq_from_if),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM contents are indexed by the low 12 address bits.
  function automatic logic [7:0] init_val(input logic [11:0] a);
    case (a)
      12'hFFE: return 8'h11;
      12'hFFF: return 8'h22;
      12'h000: return 8'h33;
      12'h001: return 8'h44;
      12'h010: return 8'h13;
      12'h011: return 8'h05;
      12'h012: return 8'h00;
      12'h013: return 8'h00;
      12'h021: return 8'hAB;
      12'h102: return 8'h77;
      12'h103: return 8'h66;
      default: return a[7:0] ^ {a[11:8], 4'h0} ^ 8'hC3;
    endcase
  endfunction

  logic       preload;
  logic [7:0] ram [4096];
  logic [7:0] ref_mem [4096];
  logic [39:0] wr_q [$];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(12'(i));
    end else begin
      ram_din <= ram[ram_a[11:0]];
      if (ram_wr === 1'b1) ram[ram_a[11:0]] <= ram_dout;
    end
  end

  always @(posedge clk) begin
    if (ram_wr === 1'b1) wr_q.push_back({ram_a, ram_dout});
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One request from an idle controller; returns in the IDLE cycle after done.
  task automatic run_txn(input string nm, input bit is_mem, input bit we,
                         input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input int exp_lat,
                         input logic [31:0] exp_data);
    int n, cyc, done_cyc;
    bit stall_ok, addr_ok, other_ok, wr_ok;
    logic [31:0] got;
    n = !is_mem ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    wr_q.delete();
    stall_ok = 1; addr_ok = 1; other_ok = 1; wr_ok = 1;
    got = 32'd0; done_cyc = -1; cyc = 0;
    if (is_mem) begin
      if_req = 0; mem_req = 1; mem_we = we; mem_addr = addr;
      mem_size = size; mem_wdata = wdata;
    end else begin
      mem_req = 0; if_req = 1; if_addr = addr;
    end
    #1;
    if ((is_mem ? stallreq_from_mem : stallreq_from_if) !== 1'b1) stall_ok = 0;
    while (done_cyc < 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc <= n && ram_a !== addr + 32'(cyc - 1)) addr_ok = 0;
      if ((is_mem ? if_done : mem_done) !== 1'b0) other_ok = 0;
      if ((is_mem ? mem_done : if_done) === 1'b1) begin
        done_cyc = cyc;
        got = is_mem ? mem_rdata : if_inst;
        if ((is_mem ? stallreq_from_mem : stallreq_from_if) !== 1'b0) stall_ok = 0;
      end else if ((is_mem ? stallreq_from_mem : stallreq_from_if) !== 1'b1) begin
        stall_ok = 0;
      end
    end
    check({nm, " latency"}, 64'(done_cyc), 64'(exp_lat));
    if (!we) check({nm, " rdata"}, 64'(got), 64'(exp_data));
    check({nm, " ram_a seq"}, 64'(addr_ok), 64'd1);
    check({nm, " stall"}, 64'(stall_ok), 64'd1);
    check({nm, " other done"}, 64'(other_ok), 64'd1);
    if (wr_q.size() != (we ? n : 0)) wr_ok = 0;
    else if (we)
      for (int i = 0; i < n; i++)
        if (wr_q[i] !== {addr + 32'(i), wdata[8*i +: 8]}) wr_ok = 0;
    check({nm, " writes"}, 64'(wr_ok), 64'd1);
    if (we)
      for (int i = 0; i < n; i++) ref_mem[12'(addr + 32'(i))] = wdata[8*i +: 8];
    @(posedge clk); #1;
    if_req = 0; mem_req = 0;
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int mdone, idone, cyc, n, lat;
    bit is_mem, we, no_done;
    logic [1:0]  size;
    logic [31:0] addr, wdata, exp;

    vecs[0] = '{0, 0, 32'h10,       2'd0, 32'h0,        6, 32'h00000513};
    vecs[1] = '{1, 0, 32'h21,       2'd0, 32'h0,        3, 32'h000000AB};
    vecs[2] = '{1, 1, 32'h100,      2'd1, 32'h1234BEEF, 3, 32'h0};
    vecs[3] = '{1, 0, 32'h100,      2'd2, 32'h0,        6, 32'h6677BEEF};
    vecs[4] = '{1, 0, 32'hFFFFFFFE, 2'd2, 32'h0,        6, 32'h44332211};
    vecs[5] = '{1, 0, 32'h10,       2'd1, 32'h0,        4, 32'h00000513};
    vecs[6] = '{1, 0, 32'h10,       2'd3, 32'h0,        6, 32'h00000513};

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

    rst = 1; preload = 1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_size = 0; mem_wdata = 0;
    @(posedge clk); #1;
    preload = 0;
    mem_req = 1; if_req = 1;
    #1;
    check("stall during reset", {62'd0, stallreq_from_mem, stallreq_from_if}, 64'd3);
    mem_req = 0; if_req = 0;
    @(posedge clk); #1;
    check("reset outputs", {ram_a, ram_dout, ram_wr, if_done, mem_done, 21'd0}, 64'd0);
    check("reset data", {if_inst, mem_rdata}, 64'd0);
    rst = 0;

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].addr,
              vecs[i].size, vecs[i].wdata, vecs[i].lat, vecs[i].data);
    check("ram[0x102] after half store", 64'(ram[12'h102]), 64'h77);

    // Both requests at once: MEM first, IF accepted the cycle after mem_done.
    mdone = -1; idone = -1; cyc = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h21; mem_size = 2'd0;
    if_req = 1; if_addr = 32'h10;
    while (idone < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done === 1'b1) mdone = cyc;
      if (if_done === 1'b1) idone = cyc;
      if (mdone >= 0 && cyc == mdone + 1) mem_req = 0;
    end
    check("arb mem_done cycle", 64'(mdone), 64'd3);
    check("arb if_done cycle", 64'(idone), 64'd10);
    check("arb data", {if_inst, mem_rdata}, {32'h00000513, 32'h000000AB});
    @(posedge clk); #1;
    if_req = 0; mem_req = 0;

    // MEM arrives mid-fetch and waits for DONE plus one IDLE cycle.
    mdone = -1; idone = -1; cyc = 0;
    if_req = 1; if_addr = 32'h10;
    while (mdone < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        mem_req = 1; mem_we = 0; mem_addr = 32'h21; mem_size = 2'd0;
      end
      if (mem_done === 1'b1) mdone = cyc;
      if (if_done === 1'b1) idone = cyc;
      if (idone >= 0 && cyc == idone + 1) if_req = 0;
    end
    check("late mem if_done cycle", 64'(idone), 64'd6);
    check("late mem mem_done cycle", 64'(mdone), 64'd10);
    @(posedge clk); #1;
    if_req = 0; mem_req = 0;

    // Reset in cycle 2 of a word store.
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_size = 2'd2; mem_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("store cycle1 wr", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h200, 8'hEF});
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("reset mid-store outputs", {ram_a, ram_dout, ram_wr, if_done, mem_done, 21'd0}, 64'd0);
    check("reset mid-store data", {if_inst, mem_rdata}, 64'd0);
    rst = 0; mem_req = 0;
    ref_mem[12'h200] = 8'hEF;
    ref_mem[12'h201] = 8'hBE;
    no_done = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_done !== 1'b0 || ram_wr !== 1'b0) no_done = 0;
    end
    check("no done after reset", 64'(no_done), 64'd1);
    run_txn("post-reset load", 1, 0, 32'h21, 2'd0, 32'h0, 3, 32'h000000AB);

    // Random traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      is_mem = 1'($urandom_range(0, 3) != 0);
      we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      size   = 2'($urandom_range(0, 3));
      addr   = 32'h800 + 32'($urandom_range(0, 60));
      wdata  = $urandom;
      n      = !is_mem ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      lat    = we ? n + 1 : n + 2;
      exp    = 32'd0;
      for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_mem[12'(addr + 32'(i))];
      run_txn($sformatf("rnd%0d", t), is_mem, we, addr, size, wdata, lat, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
